// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA timing generator (HSync/VSync, pixel counts,
//   active flag, frame-start pulse, frame counter, optional game tick).
// Latency: outputs are registered one clock behind the internal r_Col/r_Row.
// Backpressure: none; the block free-runs and has no handshakes.
// Ports:
//   i_Clk, i_Rst              pixel clock, synchronous active-high reset
//   o_HSync, o_VSync          active-low sync pulses
//   o_Col_Count, o_Row_Count  coordinates of the presented pixel
//   o_Active                  presented pixel is visible
//   o_Frame_Start             one-cycle pulse at pixel (0,0)
//   o_Frame_Count             completed-frame counter, wraps at 255
//   o_Game_Tick               pulse every c_TICK_FRAMES frames (FRAME_TICK_EN),
//                             otherwise constant 0
// Build option: define FRAME_TICK_EN to build the frame divider.
module vga_sync_gen #(
  parameter int c_TOTAL_COLS   = 800,
  parameter int c_TOTAL_ROWS   = 525,
  parameter int c_ACTIVE_COLS  = 640,
  parameter int c_ACTIVE_ROWS  = 480,
  parameter int c_H_FRONT_PORCH = 16,
  parameter int c_H_SYNC_WIDTH = 96,
  parameter int c_V_FRONT_PORCH = 10,
  parameter int c_V_SYNC_WIDTH = 2,
  parameter int c_TICK_FRAMES  = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Active,
  output logic       o_Frame_Start,
  output logic [7:0] o_Frame_Count,
  output logic       o_Game_Tick
);

  localparam logic [9:0] LP_COL_LAST  = 10'(c_TOTAL_COLS - 1);
  localparam logic [9:0] LP_ROW_LAST  = 10'(c_TOTAL_ROWS - 1);
  localparam logic [9:0] LP_ACT_COLS  = 10'(c_ACTIVE_COLS);
  localparam logic [9:0] LP_ACT_ROWS  = 10'(c_ACTIVE_ROWS);
  localparam logic [9:0] LP_HS_START  = 10'(c_ACTIVE_COLS + c_H_FRONT_PORCH);
  localparam logic [9:0] LP_HS_END    = 10'(c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH);
  localparam logic [9:0] LP_VS_START  = 10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH);
  localparam logic [9:0] LP_VS_END    = 10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH);

  logic [9:0] r_Col;
  logic [9:0] r_Row;
  // Set by reset; the first frame start after reset leaves the frame counter alone.
  logic       r_First;

  logic col_last;
  logic row_last;
  logic frame_start;
  logic hsync_n;
  logic vsync_n;
  logic active;

  always_comb begin
    col_last    = (r_Col == LP_COL_LAST);
    row_last    = (r_Row == LP_ROW_LAST);
    frame_start = (r_Col == 10'd0) && (r_Row == 10'd0);
    hsync_n     = !((r_Col >= LP_HS_START) && (r_Col < LP_HS_END));
    vsync_n     = !((r_Row >= LP_VS_START) && (r_Row < LP_VS_END));
    active      = (r_Col < LP_ACT_COLS) && (r_Row < LP_ACT_ROWS);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Col         <= 10'd0;
      r_Row         <= 10'd0;
      r_First       <= 1'b1;
      o_HSync       <= 1'b1;
      o_VSync       <= 1'b1;
      o_Col_Count   <= 10'd0;
      o_Row_Count   <= 10'd0;
      o_Active      <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Frame_Count <= 8'd0;
    end else begin
      // Line and frame wrap on the same edge both land on 0 together.
      if (col_last) begin
        r_Col <= 10'd0;
        r_Row <= row_last ? 10'd0 : r_Row + 10'd1;
      end else begin
        r_Col <= r_Col + 10'd1;
      end

      o_Col_Count   <= r_Col;
      o_Row_Count   <= r_Row;
      o_HSync       <= hsync_n;
      o_VSync       <= vsync_n;
      o_Active      <= active;
      o_Frame_Start <= frame_start;

      if (frame_start) begin
        if (r_First) begin
          r_First <= 1'b0;
        end else begin
          o_Frame_Count <= o_Frame_Count + 8'd1;
        end
      end
    end
  end

`ifdef FRAME_TICK_EN
  localparam logic [7:0] LP_TICK_LAST = 8'(c_TICK_FRAMES - 1);

  // Counts frame starts modulo c_TICK_FRAMES; the first post-reset frame is 1.
  logic [7:0] r_Tick_Cnt;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Tick_Cnt  <= 8'd0;
      o_Game_Tick <= 1'b0;
    end else begin
      o_Game_Tick <= 1'b0;
      if (frame_start) begin
        if (r_Tick_Cnt == LP_TICK_LAST) begin
          r_Tick_Cnt  <= 8'd0;
          o_Game_Tick <= 1'b1;
        end else begin
          r_Tick_Cnt <= r_Tick_Cnt + 8'd1;
        end
      end
    end
  end
`else
  assign o_Game_Tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen with shrunken timing (16x10 pixel frame) so that
// 257 frames fit in a short run. Stimulus pushes expected outputs into a queue;
// a monitor pops and compares one entry per clock.
module tb_vga_sync_gen;

  localparam int TC = 16, TR = 10, AC = 10, AR = 6;
  localparam int HFP = 2, HSW = 3, VFP = 1, VSW = 2, TICK = 4;
  localparam int FRAME = TC * TR; // 160 clocks

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [9:0] col;
    logic [9:0] row;
    logic       act;
    logic       fs;
    logic [7:0] fc;
    logic       tick;
  } out_t;

  logic       clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       o_HSync, o_VSync, o_Active, o_Frame_Start, o_Game_Tick;
  logic [9:0] o_Col_Count, o_Row_Count;
  logic [7:0] o_Frame_Count;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .c_TOTAL_COLS(TC), .c_TOTAL_ROWS(TR), .c_ACTIVE_COLS(AC), .c_ACTIVE_ROWS(AR),
    .c_H_FRONT_PORCH(HFP), .c_H_SYNC_WIDTH(HSW), .c_V_FRONT_PORCH(VFP),
    .c_V_SYNC_WIDTH(VSW), .c_TICK_FRAMES(TICK)
  ) dut (
    .i_Clk(clk), .i_Rst(i_Rst),
    .o_HSync(o_HSync), .o_VSync(o_VSync),
    .o_Col_Count(o_Col_Count), .o_Row_Count(o_Row_Count),
    .o_Active(o_Active), .o_Frame_Start(o_Frame_Start),
    .o_Frame_Count(o_Frame_Count), .o_Game_Tick(o_Game_Tick)
  );

  out_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   t = 0;        // pixels presented since the last reset
  bit   phase0 = 1'b1;

  // Observed statistics gathered by the monitor
  int         cyc = 0;
  int         n_fs = 0;
  int         last_fs = -1;
  int         prev_fc = -1;
  bit         wrap_seen = 1'b0;
  int         hs_low = 0;
  int         hs_first = -1;
  int         vs_low = 0;
  logic [9:0] tick_mask = '0;

  // Expected output for pixel index t counted from reset release.
  function automatic out_t model(input int tt);
    out_t e;
    int c, r, f;
    c = tt % TC;
    r = (tt / TC) % TR;
    f = tt / FRAME;
    e.col  = 10'(c);
    e.row  = 10'(r);
    e.hs   = !((c >= AC + HFP) && (c < AC + HFP + HSW));
    e.vs   = !((r >= AR + VFP) && (r < AR + VFP + VSW));
    e.act  = (c < AC) && (r < AR);
    e.fs   = (c == 0) && (r == 0);
    e.fc   = 8'(f % 256);
`ifdef FRAME_TICK_EN
    e.tick = e.fs && (((f + 1) % TICK) == 0);
`else
    e.tick = 1'b0;
`endif
    return e;
  endfunction

  function automatic out_t reset_vals();
    out_t e;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    return e;
  endfunction

  task automatic step(input logic rst);
    @(negedge clk);
    i_Rst = rst;
    if (rst) begin
      exp_q.push_back(reset_vals());
      t = 0;
    end else begin
      exp_q.push_back(model(t));
      t++;
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one output per clock, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    out_t e, a;
    #1;
    cyc++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Active,
           o_Frame_Start, o_Frame_Count, o_Game_Tick};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL pixel cyc=%0d got hs=%b vs=%b col=%0d row=%0d act=%b fs=%b fc=%0d tick=%b expected hs=%b vs=%b col=%0d row=%0d act=%b fs=%b fc=%0d tick=%b",
                 cyc, a.hs, a.vs, a.col, a.row, a.act, a.fs, a.fc, a.tick,
                 e.hs, e.vs, e.col, e.row, e.act, e.fs, e.fc, e.tick);
      end
      if (i_Rst) begin
        n_fs = 0;
        last_fs = -1;
      end else begin
        if (o_Frame_Start) begin
          n_fs++;
          if (last_fs >= 0) begin
            total++;
            if (cyc - last_fs != FRAME) begin
              bad++;
              $display("FAIL fs_spacing got=%0d expected=%0d", cyc - last_fs, FRAME);
            end
          end
          last_fs = cyc;
          if (phase0 && o_Frame_Count == 8'd0 && prev_fc == 255) wrap_seen = 1'b1;
          prev_fc = int'(o_Frame_Count);
          if (phase0 && n_fs <= 9 && o_Game_Tick) tick_mask[n_fs] = 1'b1;
        end
        if (phase0 && n_fs == 1 && o_Row_Count == 10'd0 && !o_HSync) begin
          if (hs_low == 0) hs_first = int'(o_Col_Count);
          hs_low++;
        end
        if (phase0 && n_fs == 1 && !o_VSync) vs_low++;
      end
    end
  end

  initial begin
    // Reset held for 5 clocks
    for (int i = 0; i < 5; i++) step(1'b1);
    // 257 complete frames
    for (int i = 0; i < 257 * FRAME; i++) step(1'b0);
    // Advance until the next presented pixel is (row 5, col 7)
    while ((t % FRAME) != 5 * TC + 7) step(1'b0);
    drain();
    check("frame_starts_257", n_fs, 258);
    check("hsync_first_col", hs_first, 12);
    check("hsync_low_clocks", hs_low, 3);
    check("vsync_low_clocks", vs_low, 32);
    check("frame_count_wrap", int'(wrap_seen), 1);
`ifdef FRAME_TICK_EN
    check("tick_frames_mask", int'(tick_mask), 10'b01_0001_0000);
`else
    check("tick_frames_mask", int'(tick_mask), 0);
`endif
    phase0 = 1'b0;
    // Single-clock reset mid-frame, then 10 more frames
    step(1'b1);
    for (int i = 0; i < 10 * FRAME; i++) step(1'b0);
    drain();
    check("frame_starts_after_rst", n_fs, 10);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
